// File: rtl/trinity_cmd_seq_if.sv
// ---------------------------------------------------------------------------
// trinity_cmd_seq_if
//   Host-side command handshake into the Trinity command sequencer.
//   master : the host (offers commands)
//   slave  : the sequencer (accepts commands into its FIFO)
// Signals
//   cmd_valid   host offers a command
//   cmd_ready   sequencer FIFO can accept (not full)
//   cmd_mode    core mode used for every beat of the command
//   cmd_data    data byte of the first beat
//   cmd_step    per-beat data increment, mod 256
//   cmd_repeat  beat count minus one (1..16 beats)
// ---------------------------------------------------------------------------
interface trinity_cmd_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_data;
  logic [7:0] cmd_step;
  logic [3:0] cmd_repeat;

  modport master (
    output cmd_valid, cmd_mode, cmd_data, cmd_step, cmd_repeat,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_data, cmd_step, cmd_repeat,
    output cmd_ready
  );
endinterface

// File: rtl/trinity_cmd_seq.sv
// ---------------------------------------------------------------------------
// trinity_cmd_seq
//   Upstream command sequencer for the Trinity accumulator core. Host commands
//   are queued in a DEPTH-entry FIFO; each command is expanded into a burst of
//   cmd_repeat+1 exec beats, one per cycle, with the data byte advancing by
//   cmd_step (mod 256) on every beat. Core-facing outputs come straight from
//   flops.
// Ports
//   sys_clk     system clock, rising edge
//   sys_rst     synchronous reset, active-high
//   cmd         command handshake (slave side)
//   pause       holds issue: no pop and no beat while high
//   bus_out     core bus word: [7]=valid [2]=exec [1:0]=mode, [6:3]=0
//   data_out    core data byte, meaningful while bus_out[7]=1, else holds
//   busy        high while a command is being issued
//   done_pulse  one-cycle pulse alongside a command's last beat
//   level       FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module trinity_cmd_seq #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  trinity_cmd_seq_if.slave     cmd,
  input  logic                 pause,
  output logic [7:0]           bus_out,
  output logic [7:0]           data_out,
  output logic                 busy,
  output logic                 done_pulse,
  output logic [ADDR_W:0]      level
);

  typedef enum logic {IDLE, ISSUE} state_e;

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] data;
    logic [7:0] step;
    logic [3:0] rpt;
  } cmd_t;

  // FIFO state
  cmd_t              mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;

  // FSM and working registers of the command being issued
  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [7:0]        cur_data_q, cur_data_d;
  logic [7:0]        step_q, step_d;
  logic [3:0]        beats_left_q, beats_left_d;

  // Registered core-facing outputs
  logic [7:0]        bus_q, bus_d;
  logic [7:0]        data_q, data_d;
  logic              done_q, done_d;

  logic              push;
  logic              pop;
  logic              empty;
  cmd_t              head;
  cmd_t              cmd_in;

  // Ready depends only on registered occupancy, so a pop in the same cycle
  // does not open the door for a push while full.
  assign cmd.cmd_ready = (level_q != (ADDR_W+1)'(DEPTH));
  assign empty         = (level_q == '0);
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign head          = mem_q[rd_ptr_q];
  assign cmd_in        = '{mode: cmd.cmd_mode, data: cmd.cmd_data,
                           step: cmd.cmd_step, rpt: cmd.cmd_repeat};

  // ------------------------------------------------------------------ FIFO
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first; a path
    // that skips an assignment would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (push && !pop)      level_d = level_q + (ADDR_W+1)'(1);
    else if (!push && pop) level_d = level_q - (ADDR_W+1)'(1);
  end

  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, and occupancy (which is reset) decides what is valid.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  // ------------------------------------------------------- state register
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!empty && !pause)              state_d = ISSUE;
      ISSUE: if (!pause && beats_left_q == '0)  state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------- outputs / datapath
  always_comb begin
    pop          = 1'b0;
    mode_d       = mode_q;
    cur_data_d   = cur_data_q;
    step_d       = step_q;
    beats_left_d = beats_left_q;
    bus_d        = '0;
    data_d       = data_q;      // data byte holds between beats
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !pause) begin
          pop          = 1'b1;
          mode_d       = head.mode;
          cur_data_d   = head.data;
          step_d       = head.step;
          beats_left_d = head.rpt;
        end
      end
      ISSUE: begin
        if (!pause) begin
          bus_d      = {1'b1, 4'b0000, 1'b1, mode_q};
          data_d     = cur_data_q;
          cur_data_d = cur_data_q + step_q;   // 8-bit wrap is intended
          if (beats_left_q == '0) done_d       = 1'b1;
          else                    beats_left_d = beats_left_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      mode_q       <= '0;
      cur_data_q   <= '0;
      step_q       <= '0;
      beats_left_q <= '0;
      bus_q        <= '0;
      data_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      mode_q       <= mode_d;
      cur_data_q   <= cur_data_d;
      step_q       <= step_d;
      beats_left_q <= beats_left_d;
      bus_q        <= bus_d;
      data_q       <= data_d;
      done_q       <= done_d;
    end
  end

  assign bus_out    = bus_q;
  assign data_out   = data_q;
  assign done_pulse = done_q;
  assign busy       = (state_q == ISSUE);
  assign level      = level_q;

endmodule

// File: tb/tb_trinity_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_trinity_cmd_seq
//   Self-checking bench for trinity_cmd_seq. Directed steps cover reset,
//   first-beat latency, data wrap, FIFO full, pause mid-burst and reset
//   mid-burst; randomized rounds are checked against a beat-list model that
//   expands each accepted command into its expected beats arithmetically.
// ---------------------------------------------------------------------------
module tb_trinity_cmd_seq;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       pause;
  logic [7:0] bus_out;
  logic [7:0] data_out;
  logic       busy;
  logic       done_pulse;
  logic [2:0] level;

  int total = 0;
  int bad   = 0;

  trinity_cmd_seq_if cif ();

  trinity_cmd_seq #(.DEPTH(4), .ADDR_W(2)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cmd        (cif.slave),
    .pause      (pause),
    .bus_out    (bus_out),
    .data_out   (data_out),
    .busy       (busy),
    .done_pulse (done_pulse),
    .level      (level)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] bus;
    logic [7:0] data;
    logic       done;
    logic       first;
  } beat_t;

  beat_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  // One clock: inputs driven before the rising edge, outputs sampled at the
  // following falling edge.
  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  // Expected beats of one command: beat i carries data + i*step (mod 256).
  task automatic model_add(input logic [1:0] m, input logic [7:0] d,
                           input logic [7:0] s, input logic [3:0] r);
    beat_t b;
    for (int i = 0; i <= int'(r); i++) begin
      b.bus   = 8'h84 | {6'b0, m};
      b.data  = 8'((int'(d) + i * int'(s)) % 256);
      b.done  = (i == int'(r));
      b.first = (i == 0);
      exp_q.push_back(b);
    end
  endtask

  task automatic push_cmd(input logic [1:0] m, input logic [7:0] d, input logic [7:0] s,
                          input logic [3:0] r, input bit exp_acc);
    check("push_ready", cif.cmd_ready, exp_acc);
    cif.cmd_valid  = 1'b1;
    cif.cmd_mode   = m;
    cif.cmd_data   = d;
    cif.cmd_step   = s;
    cif.cmd_repeat = r;
    tick();
    cif.cmd_valid  = 1'b0;
    if (exp_acc) model_add(m, d, s, r);
  endtask

  // Consume the expected beat list, comparing every observed beat. Between
  // commands there must be exactly one idle cycle unless pause is jittered.
  task automatic drain(input int budget, input bit rand_pause);
    beat_t e;
    int    gap      = 0;
    bit    seen     = 0;
    bit    in_burst = 0;
    int    n        = 0;
    while (exp_q.size() > 0 && n < budget) begin
      if (rand_pause) pause = ($urandom_range(0, 3) == 0);
      tick();
      n++;
      if (bus_out[7]) begin
        e = exp_q.pop_front();
        check("beat_bus",  bus_out,    e.bus);
        check("beat_data", data_out,   e.data);
        check("beat_done", done_pulse, e.done);
        if (e.first && seen) begin
          if (rand_pause) check("gap_min", (gap >= 1), 1);
          else            check("gap_one", gap, 1);
        end
        gap      = 0;
        seen     = 1;
        in_burst = !e.done;
      end else begin
        check("idle_bus",  bus_out,    0);
        check("idle_done", done_pulse, 0);
        if (in_burst && !pause) check("back_to_back", bus_out[7], 1);
        gap++;
      end
    end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
    pause = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("quiet_bus",   bus_out, 0);
      check("quiet_busy",  busy,    0);
      check("quiet_level", level,   0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst        = 1'b1;
    pause          = 1'b0;
    cif.cmd_valid  = 1'b0;
    cif.cmd_mode   = '0;
    cif.cmd_data   = '0;
    cif.cmd_step   = '0;
    cif.cmd_repeat = '0;

    // Reset state
    tick();
    tick();
    check("rst_bus",   bus_out,       8'h00);
    check("rst_data",  data_out,      8'h00);
    check("rst_level", level,         0);
    check("rst_ready", cif.cmd_ready, 1);
    check("rst_busy",  busy,          0);
    check("rst_done",  done_pulse,    0);
    sys_rst = 1'b0;
    tick();

    // Single command, latency and burst contents
    push_cmd(2'd0, 8'h10, 8'h05, 4'd2, 1'b1);
    exp_q.delete();
    check("t2_e0_level", level,   1);
    check("t2_e0_bus",   bus_out, 0);
    check("t2_e0_busy",  busy,    0);
    tick();
    check("t2_e1_busy",  busy,    1);
    check("t2_e1_level", level,   0);
    check("t2_e1_bus",   bus_out, 0);
    tick();
    check("t2_b0_bus",  bus_out,    8'h84);
    check("t2_b0_data", data_out,   8'h10);
    check("t2_b0_done", done_pulse, 0);
    tick();
    check("t2_b1_bus",  bus_out,    8'h84);
    check("t2_b1_data", data_out,   8'h15);
    check("t2_b1_done", done_pulse, 0);
    tick();
    check("t2_b2_bus",  bus_out,    8'h84);
    check("t2_b2_data", data_out,   8'h1A);
    check("t2_b2_done", done_pulse, 1);
    tick();
    check("t2_end_bus",  bus_out,    0);
    check("t2_end_done", done_pulse, 0);
    check("t2_end_busy", busy,       0);
    check("t2_end_hold", data_out,   8'h1A);

    // Data wraps mod 256
    push_cmd(2'd2, 8'hFE, 8'h03, 4'd1, 1'b1);
    drain(20, 1'b0);

    // FIFO full while paused, then four bursts in order
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_cmd(2'(i), 8'($urandom), 8'($urandom), 4'($urandom_range(0, 5)), (i < 4));
      check("t4_level", level, (i < 4) ? i + 1 : 4);
    end
    check("t4_full_ready", cif.cmd_ready, 0);
    // First unpaused cycle pops while full: the offer is still refused.
    pause = 1'b0;
    push_cmd(2'd3, 8'h55, 8'h01, 4'd0, 1'b0);
    check("t4_after_pop_level", level, 3);
    drain(200, 1'b0);
    idle_check(3);

    // Pause for two cycles after the first beat
    push_cmd(2'd0, 8'h00, 8'h01, 4'd3, 1'b1);
    exp_q.delete();
    tick();
    tick();
    check("t5_b0_bus",  bus_out,  8'h84);
    check("t5_b0_data", data_out, 8'h00);
    pause = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t5_p_bus",  bus_out,    0);
      check("t5_p_done", done_pulse, 0);
      check("t5_p_busy", busy,       1);
      check("t5_p_data", data_out,   8'h00);
    end
    pause = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("t5_bus",  bus_out,    8'h84);
      check("t5_data", data_out,   i);
      check("t5_done", done_pulse, (i == 3));
    end
    tick();
    check("t5_end_bus",  bus_out, 0);
    check("t5_end_busy", busy,    0);

    // Randomized rounds, some with pause jitter
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 4);
      pause = 1'b1;
      for (int i = 0; i < n; i++)
        push_cmd(2'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 1'b1);
      check("rnd_level", level, n);
      pause = 1'b0;
      drain(400, (r >= 4));
      idle_check(2);
    end

    // Reset mid-burst with two commands queued
    push_cmd(2'd1, 8'h20, 8'h01, 4'd15, 1'b1);
    push_cmd(2'd2, 8'h40, 8'h02, 4'd3,  1'b1);
    push_cmd(2'd3, 8'h60, 8'h03, 4'd3,  1'b1);
    exp_q.delete();
    check("t6_level", level, 2);
    tick();
    tick();
    check("t6_mid_bus", bus_out, 8'h85);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check("t6_rst_bus",   bus_out,       0);
    check("t6_rst_level", level,         0);
    check("t6_rst_busy",  busy,          0);
    check("t6_rst_done",  done_pulse,    0);
    check("t6_rst_ready", cif.cmd_ready, 1);
    check("t6_rst_data",  data_out,      0);
    idle_check(20);

    // Recovery after reset
    push_cmd(2'd3, 8'hF0, 8'h10, 4'd2, 1'b1);
    drain(20, 1'b0);
    idle_check(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
